// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that drives the select of a shared 4:1 mux and a one-hot grant.
// Grants last at most MAX_HOLD cycles and are always followed by one idle turnaround cycle.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          grant_reg, grant_next;
    logic [1:0]          sel_reg, sel_next;
    logic [1:0]          ptr_reg, ptr_next;
    logic                busy_reg, busy_next;
    logic                timeout_reg, timeout_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [3:0]          rot_req;
    logic [1:0]          pick_off;
    logic [1:0]          winner;
    logic                at_limit;
    logic                owner_req;
    logic                release_now;

    // Requests rotated so that bit 0 is the requester at ptr (highest priority).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        pick_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
            end
        end
    end

    assign winner      = ptr_reg + pick_off;
    assign at_limit    = (hold_cnt_reg == HOLD_W'(MAX_HOLD));
    assign owner_req   = req[sel_reg];
    assign release_now = done || !owner_req || at_limit;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        sel_next      = sel_reg;
        ptr_next      = ptr_reg;
        busy_next     = busy_reg;
        timeout_next  = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_next    = GRANT;
                    grant_next    = 4'b0001 << winner;
                    sel_next      = winner;
                    ptr_next      = winner + 2'd1;
                    busy_next     = 1'b1;
                    hold_cnt_next = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_next    = IDLE;
                    grant_next    = 4'b0000;
                    busy_next     = 1'b0;
                    hold_cnt_next = '0;
                    // Only a pure limit expiry is reported; done or withdrawal wins.
                    timeout_next  = at_limit && !done && owner_req;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= 4'b0000;
            sel_reg      <= 2'd0;
            ptr_reg      <= 2'd0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            sel_reg      <= sel_next;
            ptr_reg      <= ptr_next;
            busy_reg     <= busy_next;
            timeout_reg  <= timeout_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign grant   = grant_reg;
    assign sel     = sel_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a cycle model pushes expected outputs at each edge,
// a monitor pops and compares them on the falling edge.
module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: owner -1 means nobody holds the mux.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_tmo   = 1'b0;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Model: evaluates the arbitration rules at each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_owner = -1; m_cnt = 0; m_ptr = 0; m_sel = 0; m_tmo = 1'b0;
            end else if (m_owner < 0) begin
                m_tmo = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_ptr + k) % 4;
                    if (req[c]) begin
                        m_owner = c; m_sel = c; m_cnt = 1; m_ptr = (c + 1) % 4;
                        break;
                    end
                end
            end else begin
                bit lim;
                lim = (m_cnt == MAX_HOLD);
                if (done || !req[m_owner] || lim) begin
                    m_tmo   = lim && !done && req[m_owner];
                    m_owner = -1;
                end else begin
                    m_cnt = m_cnt + 1;
                    m_tmo = 1'b0;
                end
            end
            e.grant   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            e.sel     = 2'(m_sel);
            e.busy    = (m_owner >= 0);
            e.timeout = m_tmo;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the queued expectation.
    logic [3:0] prev_grant = 4'b0000;
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] one;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (grant !== e.grant || sel !== e.sel || busy !== e.busy || timeout !== e.timeout) begin
                errors++;
                $display("FAIL outputs t=%0t: got grant=%b sel=%0d busy=%b timeout=%b, expected grant=%b sel=%0d busy=%b timeout=%b",
                         $time, grant, sel, busy, timeout, e.grant, e.sel, e.busy, e.timeout);
            end else if (e.grant != 4'b0000 && prev_grant == 4'b0000) begin
                $display("t=%0t grant=%b sel=%0d", $time, grant, sel);
            end else if (e.timeout) begin
                $display("t=%0t timeout after owner %0d", $time, sel);
            end
            prev_grant = e.grant;
            one = 4'b0001 << sel;
            checks++;
            if (!(grant == 4'b0000 || $onehot(grant)) || busy !== (|grant) || (busy && grant != one)) begin
                errors++;
                $display("FAIL invariant t=%0t: grant=%b sel=%0d busy=%b", $time, grant, sel, busy);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; req = 4'hF; done = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Round-robin with done on the second grant cycle.
        for (int c = 0; c < 30; c++) begin
            step();
            done = (m_owner >= 0) && (m_cnt == 2);
        end

        // Single requester, never done: limit expiry and re-grant.
        done = 1'b0; req = 4'b0100;
        for (int c = 0; c < 30; c++) step();

        // Owner 1 withdraws on its third grant cycle.
        for (int c = 0; c < 40; c++) begin
            step();
            req = (m_owner == 1 && m_cnt == 3) ? 4'b0100 : 4'b0110;
        end

        // done coincides with the hold limit.
        req = 4'hF;
        for (int c = 0; c < 40; c++) begin
            step();
            done = (m_owner >= 0) && (m_cnt == MAX_HOLD);
        end
        done = 1'b0;

        // Asynchronous reset while requester 3 owns the mux.
        req = 4'b1000; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (m_owner == 3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_owner3: got owner %0d, expected 3 within 20 cycles", m_owner);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b busy=%b sel=%0d timeout=%b, expected 0000/0/0/0",
                     grant, busy, sel, timeout);
        end
        repeat (2) step();
        req = 4'hF; rst_n = 1'b1;
        for (int c = 0; c < 10; c++) step();

        // Randomized traffic: slowly changing requests, occasional done.
        for (int c = 0; c < 1500; c++) begin
            step();
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 9) == 0);
        end

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
